// File: rtl/alu_flag_register.sv
// NZCV flag register with LEGv8 B.cond evaluation and a saturating update counter.
// Optional FLAG_BYPASS_EN: when defined, condition evaluation uses the incoming flags while set_flags is high.
module alu_flag_register #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             negative_in,
   input  logic             zero_in,
   input  logic             carry_in,
   input  logic             overflow_in,
   input  logic             set_flags,
   input  logic [3:0]       cond,
   output logic [3:0]       flags_q,
   output logic             flags_valid,
   output logic             cond_true,
   output logic [CNT_W-1:0] upd_count
);

   logic [3:0] new_flags;
   logic [3:0] eval_flags;

   assign new_flags = {negative_in, zero_in, carry_in, overflow_in};

   // Condition codes evaluated on {N,Z,C,V}; AL and NV are both unconditional on LEGv8.
   function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] c);
      logic n, z, cy, v;
      logic r;
      n  = f[3];
      z  = f[2];
      cy = f[1];
      v  = f[0];
      case (c)
         4'h0:    r = z;
         4'h1:    r = !z;
         4'h2:    r = cy;
         4'h3:    r = !cy;
         4'h4:    r = n;
         4'h5:    r = !n;
         4'h6:    r = v;
         4'h7:    r = !v;
         4'h8:    r = cy & !z;
         4'h9:    r = !(cy & !z);
         4'hA:    r = (n == v);
         4'hB:    r = (n != v);
         4'hC:    r = !z & (n == v);
         4'hD:    r = !(!z & (n == v));
         default: r = 1'b1;
      endcase
      return r;
   endfunction

`ifdef FLAG_BYPASS_EN
   // Forward the flags being written so a B.cond right behind a SUBS needs no stall.
   assign eval_flags = set_flags ? new_flags : flags_q;
`else
   assign eval_flags = flags_q;
`endif

   assign cond_true = cond_eval(eval_flags, cond);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q     <= RESET_FLAGS;
         flags_valid <= 1'b0;
         upd_count   <= '0;
      end else if (set_flags) begin
         flags_q     <= new_flags;
         flags_valid <= 1'b1;
         if (upd_count != {CNT_W{1'b1}})
            upd_count <= upd_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_alu_flag_register.sv
// Bench for alu_flag_register: table vectors, hand sequences and random traffic vs. a behavioural model.
// Two instances share stimulus: default counter width and a 4-bit counter for saturation.
module tb_alu_flag_register;

   logic        clk = 1'b0;
   logic        reset;
   logic        negative_in, zero_in, carry_in, overflow_in, set_flags;
   logic [3:0]  cond;
   logic [3:0]  flags_q, flags_q4;
   logic        flags_valid, flags_valid4, cond_true, cond_true4;
   logic [15:0] upd_count;
   logic [3:0]  upd_count4;

   int compared = 0;
   int mismatched = 0;

   // model state
   logic [3:0] m_flags;
   logic       m_valid;
   int         m_cnt;

   always #5 clk = ~clk;

   alu_flag_register dut (
      .clk(clk), .reset(reset), .negative_in(negative_in), .zero_in(zero_in),
      .carry_in(carry_in), .overflow_in(overflow_in), .set_flags(set_flags), .cond(cond),
      .flags_q(flags_q), .flags_valid(flags_valid), .cond_true(cond_true), .upd_count(upd_count)
   );

   alu_flag_register #(.RESET_FLAGS(4'b0000), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .negative_in(negative_in), .zero_in(zero_in),
      .carry_in(carry_in), .overflow_in(overflow_in), .set_flags(set_flags), .cond(cond),
      .flags_q(flags_q4), .flags_valid(flags_valid4), .cond_true(cond_true4), .upd_count(upd_count4)
   );

   typedef struct {
      logic [3:0] nzcv;
      logic [3:0] cnd;
      logic       exp;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Condition as a base test plus an inversion bit, rather than a 16-entry lookup.
   function automatic bit model_cond(input logic [3:0] f, input logic [3:0] cd);
      bit n, z, c, v, r;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cd >> 1)
         0: r = z;
         1: r = c;
         2: r = n;
         3: r = v;
         4: r = c && !z;
         5: r = (n == v);
         6: r = !z && (n == v);
         default: r = 1;
      endcase
      if (cd[0] && cd != 4'hF) r = !r;
      return r;
   endfunction

   function automatic logic [3:0] eval_flags_model();
`ifdef FLAG_BYPASS_EN
      if (set_flags) return {negative_in, zero_in, carry_in, overflow_in};
`endif
      return m_flags;
   endfunction

   task automatic model_reset();
      m_flags = 4'b0000;
      m_valid = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic model_update();
      if (set_flags) begin
         m_flags = {negative_in, zero_in, carry_in, overflow_in};
         m_valid = 1'b1;
         if (m_cnt < 65535) m_cnt++;
      end
   endtask

   task automatic check_all();
      check("cond_true", cond_true, model_cond(eval_flags_model(), cond));
      check("cond_true4", cond_true4, model_cond(eval_flags_model(), cond));
      check("flags_q", flags_q, m_flags);
      check("flags_q4", flags_q4, m_flags);
      check("flags_valid", flags_valid, m_valid);
      check("upd_count", upd_count, m_cnt);
      check("upd_count4", upd_count4, (m_cnt > 15) ? 15 : m_cnt);
   endtask

   task automatic drive(input logic sf, input logic [3:0] f, input logic [3:0] cd);
      set_flags   = sf;
      negative_in = f[3];
      zero_in     = f[2];
      carry_in    = f[1];
      overflow_in = f[0];
      cond        = cd;
   endtask

   // One cycle: drive at negedge, check mid-cycle, advance model on the rising edge.
   task automatic step(input logic sf, input logic [3:0] f, input logic [3:0] cd);
      @(negedge clk);
      drive(sf, f, cd);
      #1 check_all();
      @(posedge clk);
      model_update();
   endtask

   initial begin
      tbl[0]  = '{4'b0100, 4'h0, 1'b1};
      tbl[1]  = '{4'b0100, 4'h1, 1'b0};
      tbl[2]  = '{4'b0010, 4'h2, 1'b1};
      tbl[3]  = '{4'b0000, 4'h3, 1'b1};
      tbl[4]  = '{4'b1000, 4'h4, 1'b1};
      tbl[5]  = '{4'b1000, 4'h5, 1'b0};
      tbl[6]  = '{4'b0001, 4'h6, 1'b1};
      tbl[7]  = '{4'b0001, 4'h7, 1'b0};
      tbl[8]  = '{4'b0010, 4'h8, 1'b1};
      tbl[9]  = '{4'b0110, 4'h9, 1'b1};
      tbl[10] = '{4'b1000, 4'hA, 1'b0};
      tbl[11] = '{4'b1000, 4'hB, 1'b1};
      tbl[12] = '{4'b1001, 4'hC, 1'b1};
      tbl[13] = '{4'b1101, 4'hD, 1'b1};
      tbl[14] = '{4'b0000, 4'hE, 1'b1};
      tbl[15] = '{4'b0000, 4'hF, 1'b1};

      reset = 1'b1;
      drive(1'b0, 4'b0000, 4'h0);
      model_reset();
      #2 check_all();
      check("reset_flags", flags_q, 4'b0000);
      @(negedge clk);
      reset = 1'b0;

      // load 1111 with five updates, then async reset mid-cycle
      for (int i = 0; i < 5; i++) step(1'b1, 4'b1111, 4'h0);
      step(1'b0, 4'b0000, 4'hE);
      check("pre_reset_cnt", upd_count, 5);
      @(negedge clk);
      drive(1'b1, 4'b1111, 4'h0);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("async_flags", flags_q, 4'b0000);
      check("async_valid", flags_valid, 1'b0);
      check("async_cnt", upd_count, 0);
      @(posedge clk);
      @(negedge clk);
      check_all();
      set_flags = 1'b0;
      reset = 1'b0;

      // Z only: EQ true, NE false
      step(1'b1, 4'b0100, 4'h0);
      step(1'b0, 4'b0000, 4'h0);
      check("eq_after_z", cond_true, 1'b1);
      check("z_flags", flags_q, 4'b0100);
      check("z_valid", flags_valid, 1'b1);
      check("z_cnt", upd_count, 1);
      step(1'b0, 4'b0000, 4'h1);
      check("ne_after_z", cond_true, 1'b0);

      // table vectors
      for (int i = 0; i < 16; i++) begin
         step(1'b1, tbl[i].nzcv, 4'h0);
         @(negedge clk);
         drive(1'b0, ~tbl[i].nzcv, tbl[i].cnd);
         #1 check($sformatf("tbl%0d", i), cond_true, tbl[i].exp);
         @(posedge clk);
      end

      // full sweep: 16 flag values x 16 codes
      for (int f = 0; f < 16; f++) begin
         step(1'b1, f[3:0], 4'h0);
         for (int cd = 0; cd < 16; cd++) step(1'b0, ~f[3:0], cd[3:0]);
      end

      // hold for 10 cycles with toggling inputs
      step(1'b1, 4'b1010, 4'h0);
      for (int i = 0; i < 10; i++) step(1'b0, (i % 2) ? 4'b1111 : 4'b0000, i[3:0]);
      check("hold_flags", flags_q, 4'b1010);

      // 4-bit counter saturation
      @(negedge clk);
      reset = 1'b1;
      set_flags = 1'b0;
      #1 model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) step(1'b1, i[3:0], 4'h0);
      step(1'b0, 4'b0000, 4'h0);
      check("sat4", upd_count4, 4'hF);
      check("cnt20", upd_count, 20);

      // same-cycle set_flags and B.cond
      step(1'b1, 4'b0100, 4'h0);
      @(negedge clk);
      drive(1'b1, 4'b0000, 4'h0);
`ifdef FLAG_BYPASS_EN
      #1 check("bypass_eq", cond_true, 1'b0);
`else
      #1 check("bypass_eq", cond_true, 1'b1);
`endif
      @(posedge clk);
      model_update();
      @(negedge clk);
      drive(1'b0, 4'b0100, 4'h0);
      #1 check("post_set_eq", cond_true, 1'b0);
      @(posedge clk);

      // random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
